vga_fb_write_ctrl: RTL and testbench
====================================

// Module: vga_fb_write_ctrl
// PURPOSE
//  Sequences all writes into the VGA framebuffer (pic) write port; the scan-out read side is untouched.
//  Buffers CPU pixel writes (bus window 0x5xxx_xxxx) and decodes control registers (window 0x6xxx_xxxx).
//  Runs a hardware rectangle-fill engine and arbitrates it round-robin against buffered CPU writes.
//  Sits between the SoC slave write channel and the framebuffer inside the Vga top.
// PARAMETERS
//  QDEPTH   2    bus-write queue entries, power of two, >=2
//  AW       19   framebuffer address width, {y[8:0], x[9:0]}
//  DW       24   pixel width, {r,g,b}
// PORTS
//  Clk               in   1   single clock for the whole block
//  Rst               in   1   synchronous reset, active-high
//  WriteValid        in   1   bus write request
//  WriteAddrIn       in   32  bus write address
//  WriteDataIn       in   32  bus write data
//  WriteStrb         in   4   byte strobes
//  SlaverWriteReady  out  1   bus write accepted when WriteValid && SlaverWriteReady
//  InVblank          in   1   high during vertical blanking (used only with FB_VBLANK_GATE_EN)
//  FbWriteAddr       out  19  framebuffer write address
//  FbWriteData       out  24  framebuffer write data
//  FbWriteEnable     out  1   framebuffer write request
//  FbWriteOk         in   1   write retires in any cycle where FbWriteEnable && FbWriteOk
//  FillBusy          out  1   fill engine active
//  FillDone          out  1   one-cycle pulse when a fill completes
//  StrbError         out  1   sticky: a pixel write arrived with WriteStrb[2:0] != 3'b111
// BEHAVIOUR
//  Reset values: all outputs 0; queue empty; fill FSM F_IDLE; X0, Y0, X1, Y1, COLOR = 0.
//  SlaverWriteReady = !queue_full; it is not a registered output. All bus writes enter the queue in arrival order.
//  Pixel entry (addr[31:28]=5): FB address = addr[18:0]; data = WriteDataIn[23:0].
//  Bad-strobe pixel: if WriteStrb[2:0]!=3'b111, the entry is dropped at dequeue and StrbError is set until Rst.
//  Control entry (addr[31:28]=6), offset addr[3:0]:
//    0x0: X0 = d[9:0], Y0 = d[25:16]
//    0x4: X1 = d[9:0], Y1 = d[25:16]
//    0x8: COLOR = d[23:0]
//    0xC: GO when d[0] = 1
//  Control entries retire in one cycle without using the FB port. A control entry at the queue head stalls while FillBusy.
//  Any other address is accepted and silently dropped.
//  FB port outputs are registered.
//    Pixel accepted into an empty queue with fill idle -> FbWriteEnable high on the next cycle.
//    Once FbWriteEnable is high, FbWriteAddr and FbWriteData hold stable until FbWriteOk.
//    Back-to-back writes are allowed; with FbWriteOk tied high the sustained rate is 1 write/cycle.
//  Arbitration:
//    When queue-pixel and fill are both pending, grant alternates, starting with queue after reset.
//    A single requester gets every slot.
//  Fill FSM:
//    F_IDLE -> F_RUN on GO.
//    F_RUN emits COLOR at (x,y) in raster order from (X0,Y0): x++; when x = X1, x = X0 and y++.
//    After (X1,Y1) retires -> F_DONE.
//    F_DONE pulses FillDone for 1 cycle -> F_IDLE.
//    Empty rectangle (X0>X1 or Y0>Y1): GO -> F_DONE directly; no writes; FillDone on the cycle after GO retires.
//    Coordinates are used unclipped; the address is {y[8:0], x[9:0]}.
//  Simultaneous events: enqueue and dequeue in the same cycle while full is legal; ready stays 0 that cycle.
//  Reset mid-fill or mid-handshake: the next cycle is in the reset state and the pending write is abandoned.
// CONFIGURATION
//  FB_VBLANK_GATE_EN defined:
//    A new FB write is launched only while InVblank = 1.
//    A write already presented completes regardless of InVblank.
//    Control entries are not gated.
//  FB_VBLANK_GATE_EN undefined: InVblank is ignored; writes launch whenever granted.
// STRUCTURE
//  Package vga_fb_pkg:
//    window IDs 4'h5 and 4'h6
//    register offsets 0x0, 0x4, 0x8, 0xC
//    fill FSM enum {F_IDLE, F_RUN, F_DONE}
//    queue entry struct {addr[31:0], data[31:0], strb[3:0]}
//  Sub-module fb_wr_fifo: synchronous FIFO, QDEPTH entries, with full/empty flags.
//  Arbiter, register decode and fill FSM stay in this module.
// TESTING
//  Pixel write 0x5000_0405 / 0x00AB_CDEF, FbWriteOk=1 -> next cycle Enable=1, Addr=0x00405, Data=0xABCDEF.
//  Three pixel writes with FbWriteOk=0 -> third sees SlaverWriteReady=0. Raise Ok -> queue drains in order.
//  Regs X0=2, Y0=1, X1=3, Y1=2, COLOR=0xFF0000, GO -> 4 writes to 0x00402, 0x00403, 0x00802, 0x00803, then one FillDone pulse.
//  Pixel writes issued during a fill -> queue and fill writes alternate; fill totals are correct; no loss.
//  X0=5, X1=4, GO -> no FB writes; FillDone pulses once; FillBusy drops.
//  Pixel write with WriteStrb=4'b0011 -> no FB write; StrbError=1 until Rst.
//  With FB_VBLANK_GATE_EN and InVblank=0 -> no Enable. InVblank=1 -> writes issue.
//  Rst asserted mid-fill -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared definitions for the VGA framebuffer write controller: bus windows,
// control register offsets, fill FSM states and the queued bus-write record.
package vga_fb_pkg;

  localparam logic [3:0] WIN_PIX   = 4'h5;
  localparam logic [3:0] WIN_CTRL  = 4'h6;

  localparam logic [3:0] REG_P0    = 4'h0;
  localparam logic [3:0] REG_P1    = 4'h4;
  localparam logic [3:0] REG_COLOR = 4'h8;
  localparam logic [3:0] REG_GO    = 4'hC;

  typedef enum logic [1:0] {F_IDLE, F_RUN, F_DONE} fill_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } q_entry_t;

  // Pixels carry 24 bits, so only the low three byte lanes must be enabled.
  function automatic logic strb_ok(input logic [3:0] s);
    return (s | 4'b1000) == 4'hF;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO for queued bus writes; the head entry is visible on rdata
// whenever empty is low.
module fb_wr_fifo
  import vga_fb_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  q_entry_t                 wdata,
  output q_entry_t                 rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] ONE = 1;

  q_entry_t mem [QDEPTH];
  logic [PW:0] wptr;
  logic [PW:0] rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + ONE;
      if (pop)  rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[PW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[PW-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (count == (PW+1)'(QDEPTH));

endmodule

// File: rtl/vga_fb_write_ctrl.sv
// Framebuffer write sequencer: queues bus writes, decodes fill registers, runs the
// rectangle-fill engine and shares the FB write port round-robin. Option: FB_VBLANK_GATE_EN.
module vga_fb_write_ctrl
  import vga_fb_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int AW     = 19,
  parameter int DW     = 24
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          WriteValid,
  input  logic [31:0]   WriteAddrIn,
  input  logic [31:0]   WriteDataIn,
  input  logic [3:0]    WriteStrb,
  output logic          SlaverWriteReady,
  input  logic          InVblank,
  output logic [AW-1:0] FbWriteAddr,
  output logic [DW-1:0] FbWriteData,
  output logic          FbWriteEnable,
  input  logic          FbWriteOk,
  output logic          FillBusy,
  output logic          FillDone,
  output logic          StrbError
);

  localparam int CW = $clog2(QDEPTH) + 1;

  q_entry_t      in_ent, fifo_head, head;
  logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CW-1:0] fifo_count;
  logic          queue_full, in_fire, head_valid, head_pix, head_ctrl, head_bad, head_drop;
  logic          consume, slot_free, launch_gate, launch_ok, retire;
  logic          q_req, f_req, grant_q, grant_f, ctrl_take, go_take;
  logic          inflight_q, fb_last, prio_fill, fill_sent_all;
  logic [9:0]    x0, y0, x1, y1, fx, fy;
  logic [DW-1:0] color;
  logic          at_x_end, at_last, rect_empty;
  fill_state_t   state_q, state_d;
  logic          unused_bits;

  assign in_ent = {WriteAddrIn, WriteDataIn, WriteStrb};

  // A queue pixel on the FB port keeps its slot until it retires.
  assign queue_full       = fifo_full || (inflight_q && fifo_count == CW'(QDEPTH - 1));
  assign SlaverWriteReady = !queue_full && !Rst;
  assign in_fire          = WriteValid && SlaverWriteReady;

  // An empty FIFO is bypassed so a lone pixel reaches the FB port one cycle after acceptance.
  assign head_valid = !fifo_empty || in_fire;
  assign head       = fifo_empty ? in_ent : fifo_head;
  assign head_pix   = (head.addr[31:28] == WIN_PIX);
  assign head_ctrl  = (head.addr[31:28] == WIN_CTRL);
  assign head_bad   = head_valid && head_pix && !strb_ok(head.strb);
  assign head_drop  = head_valid && !head_ctrl && !(head_pix && strb_ok(head.strb));

  assign FillBusy  = (state_q != F_IDLE);
  assign FillDone  = (state_q == F_DONE);
  assign slot_free = !FbWriteEnable || FbWriteOk;
  assign retire    = FbWriteEnable && FbWriteOk;

`ifdef FB_VBLANK_GATE_EN
  assign launch_gate = InVblank;
  assign unused_bits = ^{head.addr[27:AW], head.data[31:26]};
`else
  assign launch_gate = 1'b1;
  assign unused_bits = ^{InVblank, head.addr[27:AW], head.data[31:26]};
`endif

  assign launch_ok  = slot_free && launch_gate;
  assign q_req      = head_valid && head_pix && strb_ok(head.strb);
  assign f_req      = (state_q == F_RUN) && !fill_sent_all;
  assign grant_q    = launch_ok && q_req && (!f_req || !prio_fill);
  assign grant_f    = launch_ok && f_req && (!q_req || prio_fill);
  assign ctrl_take  = head_valid && head_ctrl && !FillBusy;
  assign go_take    = ctrl_take && (head.addr[3:0] == REG_GO) && head.data[0];
  assign consume    = grant_q || ctrl_take || head_drop;
  assign fifo_pop   = consume && !fifo_empty;
  assign fifo_push  = in_fire && !(fifo_empty && consume);

  assign at_x_end   = (fx == x1);
  assign at_last    = at_x_end && (fy == y1);
  assign rect_empty = (x0 > x1) || (y0 > y1);

  fb_wr_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (Clk),
    .rst   (Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_ent),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= F_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE:  if (go_take) state_d = rect_empty ? F_DONE : F_RUN;
      F_RUN:   if (retire && fb_last) state_d = F_DONE;
      F_DONE:  state_d = F_IDLE;
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      FbWriteEnable <= 1'b0;
      FbWriteAddr   <= '0;
      FbWriteData   <= '0;
      StrbError     <= 1'b0;
      inflight_q    <= 1'b0;
      fb_last       <= 1'b0;
      prio_fill     <= 1'b0;
      fill_sent_all <= 1'b0;
      x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0;
      fx <= '0; fy <= '0;
      color <= '0;
    end else begin
      if (grant_q) begin
        FbWriteEnable <= 1'b1;
        FbWriteAddr   <= head.addr[AW-1:0];
        FbWriteData   <= head.data[DW-1:0];
      end else if (grant_f) begin
        FbWriteEnable <= 1'b1;
        FbWriteAddr   <= AW'({fy[8:0], fx});
        FbWriteData   <= color;
      end else if (retire) begin
        FbWriteEnable <= 1'b0;
      end

      if (grant_q || grant_f) begin
        inflight_q <= grant_q;
        fb_last    <= grant_f && at_last;
      end else if (retire) begin
        inflight_q <= 1'b0;
        fb_last    <= 1'b0;
      end

      // Priority flips only on contested slots, so the first contest after reset goes to the queue.
      if (q_req && f_req && launch_ok) prio_fill <= grant_q;

      if (head_bad) StrbError <= 1'b1;

      if (ctrl_take) begin
        case (head.addr[3:0])
          REG_P0:    begin x0 <= head.data[9:0]; y0 <= head.data[25:16]; end
          REG_P1:    begin x1 <= head.data[9:0]; y1 <= head.data[25:16]; end
          REG_COLOR: color <= head.data[DW-1:0];
          default:   ;
        endcase
      end

      if (go_take) begin
        fx            <= x0;
        fy            <= y0;
        fill_sent_all <= 1'b0;
      end else if (grant_f) begin
        if (at_last)       fill_sent_all <= 1'b1;
        else if (at_x_end) begin fx <= x0; fy <= fy + 10'd1; end
        else               fx <= fx + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_write_ctrl.sv
// Directed bench for vga_fb_write_ctrl: single-write vector table plus sequences for
// backpressure, fills, arbitration, empty rectangles, bad strobes and mid-fill reset.
module tb_vga_fb_write_ctrl;
  import vga_fb_pkg::*;

  localparam int AW = 19;
  localparam int DW = 24;
  localparam int EW = AW + DW;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          WriteValid = 1'b0;
  logic [31:0]   WriteAddrIn = '0;
  logic [31:0]   WriteDataIn = '0;
  logic [3:0]    WriteStrb = '0;
  logic          SlaverWriteReady;
`ifdef FB_VBLANK_GATE_EN
  logic          InVblank = 1'b1;
`else
  logic          InVblank = 1'b0;
`endif
  logic [AW-1:0] FbWriteAddr;
  logic [DW-1:0] FbWriteData;
  logic          FbWriteEnable;
  logic          FbWriteOk = 1'b1;
  logic          FillBusy, FillDone, StrbError;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;
  logic [EW-1:0] exp_q[$];

  vga_fb_write_ctrl dut (
    .Clk(Clk), .Rst(Rst), .WriteValid(WriteValid), .WriteAddrIn(WriteAddrIn),
    .WriteDataIn(WriteDataIn), .WriteStrb(WriteStrb), .SlaverWriteReady(SlaverWriteReady),
    .InVblank(InVblank), .FbWriteAddr(FbWriteAddr), .FbWriteData(FbWriteData),
    .FbWriteEnable(FbWriteEnable), .FbWriteOk(FbWriteOk), .FillBusy(FillBusy),
    .FillDone(FillDone), .StrbError(StrbError)
  );

  // clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0]   addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // scoreboard: every retiring FB write must match the head of exp_q
  always @(negedge Clk) begin
    logic [EW-1:0] e;
    #1;
    if (mon_en && !Rst && FbWriteEnable && FbWriteOk) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fb_write_unexpected: got addr 0x%05h data 0x%06h, none expected",
                 FbWriteAddr, FbWriteData);
      end else begin
        e = exp_q.pop_front();
        if ({FbWriteAddr, FbWriteData} !== e) begin
          n_fail++;
          $display("FAIL fb_write_order: got addr 0x%05h data 0x%06h expected addr 0x%05h data 0x%06h",
                   FbWriteAddr, FbWriteData, e[EW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int waited;
    waited = 0;
    WriteValid = 1'b1; WriteAddrIn = a; WriteDataIn = d; WriteStrb = s;
    while (!SlaverWriteReady && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    if (!SlaverWriteReady) begin
      n_checks++; n_fail++;
      $display("FAIL bus_write_timeout: ready stayed 0 for addr 0x%08h", a);
    end
    @(negedge Clk);
    WriteValid = 1'b0;
  endtask

  task automatic program_rect(input logic [9:0] x0, input logic [9:0] y0, input logic [9:0] x1,
                              input logic [9:0] y1, input logic [23:0] col);
    bus_write(32'h6000_0000, {6'd0, y0, 6'd0, x0}, 4'hF);
    bus_write(32'h6000_0004, {6'd0, y1, 6'd0, x1}, 4'hF);
    bus_write(32'h6000_0008, {8'd0, col}, 4'hF);
  endtask

  task automatic fill_wait(input int max_cyc, output int done_cnt);
    done_cnt = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge Clk);
      if (FillDone) done_cnt++;
      if (done_cnt > 0 && !FillBusy) break;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    int dc;
    vecs[0] = '{32'h5000_0405, 32'h00AB_CDEF, 4'hF,    1'b1, 19'h00405, 24'hABCDEF};
    vecs[1] = '{32'h5007_FFFF, 32'hFF12_3456, 4'b0111, 1'b1, 19'h7FFFF, 24'h123456};
    vecs[2] = '{32'h5000_0000, 32'h0000_0001, 4'hF,    1'b1, 19'h00000, 24'h000001};
    vecs[3] = '{32'h7000_0010, 32'h1234_5678, 4'hF,    1'b0, 19'h00000, 24'h000000};
    vecs[4] = '{32'h5123_4567, 32'h0055_AA33, 4'hF,    1'b1, 19'h34567, 24'h55AA33};
    vecs[5] = '{32'h6000_0008, 32'h0012_3456, 4'hF,    1'b0, 19'h00000, 24'h000000};

    // reset state
    idle(2);
    check("rst_ready", SlaverWriteReady, 0);
    check("rst_en", FbWriteEnable, 0);
    check("rst_addr", FbWriteAddr, 0);
    check("rst_data", FbWriteData, 0);
    check("rst_busy", FillBusy, 0);
    check("rst_done", FillDone, 0);
    check("rst_strb_err", StrbError, 0);
    Rst = 1'b0;
    idle(1);
    check("ready_after_rst", SlaverWriteReady, 1);

    // single-write vector table
    for (int i = 0; i < 6; i++) begin
      bus_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      check($sformatf("vec%0d_en", i), FbWriteEnable, vecs[i].exp_en);
      if (vecs[i].exp_en) begin
        check($sformatf("vec%0d_addr", i), FbWriteAddr, vecs[i].exp_addr);
        check($sformatf("vec%0d_data", i), FbWriteData, vecs[i].exp_data);
      end
    end
    idle(2);
    check("table_idle_en", FbWriteEnable, 0);

    // backpressure: third write sees a full queue, then drains in order
    mon_en = 1'b1;
    exp_q.push_back({19'h00011, 24'h000011});
    exp_q.push_back({19'h00022, 24'h000022});
    exp_q.push_back({19'h00033, 24'h000033});
    FbWriteOk = 1'b0;
    bus_write(32'h5000_0011, 32'h0000_0011, 4'hF);
    bus_write(32'h5000_0022, 32'h0000_0022, 4'hF);
    check("bp_ready_full", SlaverWriteReady, 0);
    check("bp_hold_en", FbWriteEnable, 1);
    check("bp_hold_addr", FbWriteAddr, 19'h00011);
    FbWriteOk = 1'b1;
    bus_write(32'h5000_0033, 32'h0000_0033, 4'hF);
    idle(4);
    check("bp_drain", exp_q.size(), 0);

    // 2x2 fill
    exp_q.push_back({19'h00402, 24'hFF0000});
    exp_q.push_back({19'h00403, 24'hFF0000});
    exp_q.push_back({19'h00802, 24'hFF0000});
    exp_q.push_back({19'h00803, 24'hFF0000});
    program_rect(10'd2, 10'd1, 10'd3, 10'd2, 24'hFF0000);
    bus_write(32'h6000_000C, 32'h1, 4'hF);
    check("fill_busy_start", FillBusy, 1);
    fill_wait(40, dc);
    check("fill_done_pulses", dc, 1);
    check("fill_busy_clear", FillBusy, 0);
    check("fill_drain", exp_q.size(), 0);

    // pixels during a fill alternate with fill writes
    exp_q.push_back({19'h00100, 24'h000111});
    exp_q.push_back({19'h00000, 24'h0000AA});
    exp_q.push_back({19'h00101, 24'h000222});
    exp_q.push_back({19'h00001, 24'h0000AA});
    exp_q.push_back({19'h00102, 24'h000333});
    exp_q.push_back({19'h00002, 24'h0000AA});
    exp_q.push_back({19'h00003, 24'h0000AA});
    program_rect(10'd0, 10'd0, 10'd3, 10'd0, 24'h0000AA);
    bus_write(32'h6000_000C, 32'h1, 4'hF);
    bus_write(32'h5000_0100, 32'h0000_0111, 4'hF);
    bus_write(32'h5000_0101, 32'h0000_0222, 4'hF);
    bus_write(32'h5000_0102, 32'h0000_0333, 4'hF);
    fill_wait(40, dc);
    check("mix_done_pulses", dc, 1);
    check("mix_drain", exp_q.size(), 0);

    // empty rectangle: done pulse, no writes
    program_rect(10'd5, 10'd0, 10'd4, 10'd0, 24'h00FF00);
    bus_write(32'h6000_000C, 32'h1, 4'hF);
    check("empty_done", FillDone, 1);
    check("empty_no_en", FbWriteEnable, 0);
    idle(1);
    check("empty_done_once", FillDone, 0);
    check("empty_busy_drop", FillBusy, 0);
    idle(3);
    check("empty_no_writes", exp_q.size(), 0);

    // bad strobe pixel is dropped and flags a sticky error
    bus_write(32'h5000_0123, 32'h00C0_FFEE, 4'b0011);
    check("strb_no_en", FbWriteEnable, 0);
    check("strb_err_set", StrbError, 1);
    idle(5);
    check("strb_err_sticky", StrbError, 1);

    // reset in the middle of a large fill
    mon_en = 1'b0;
    program_rect(10'd0, 10'd0, 10'd9, 10'd9, 24'h123456);
    bus_write(32'h6000_000C, 32'h1, 4'hF);
    idle(3);
    check("mid_busy", FillBusy, 1);
    check("mid_en", FbWriteEnable, 1);
    Rst = 1'b1;
    idle(1);
    check("mid_rst_en", FbWriteEnable, 0);
    check("mid_rst_addr", FbWriteAddr, 0);
    check("mid_rst_data", FbWriteData, 0);
    check("mid_rst_busy", FillBusy, 0);
    check("mid_rst_done", FillDone, 0);
    check("mid_rst_strb_err", StrbError, 0);
    check("mid_rst_ready", SlaverWriteReady, 0);
    Rst = 1'b0;
    idle(1);
    mon_en = 1'b1;
    exp_q.push_back({19'h00555, 24'h0A0B0C});
    bus_write(32'h5000_0555, 32'h000A_0B0C, 4'hF);
    idle(3);
    check("post_rst_drain", exp_q.size(), 0);

`ifdef FB_VBLANK_GATE_EN
    // launches wait for vertical blanking
    InVblank = 1'b0;
    exp_q.push_back({19'h00777, 24'h777777});
    bus_write(32'h5000_0777, 32'h0077_7777, 4'hF);
    check("vb_gate_hold", FbWriteEnable, 0);
    idle(3);
    check("vb_gate_hold_late", FbWriteEnable, 0);
    InVblank = 1'b1;
    idle(1);
    check("vb_launch_en", FbWriteEnable, 1);
    check("vb_launch_addr", FbWriteAddr, 19'h00777);
    idle(2);
    check("vb_drain", exp_q.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
